des_block_loader: RTL and testbench
===================================

DES_BLOCK_LOADER -- requirements
Module: des_block_loader

Interface
REQ-001 Parameter IDLE_TIMEOUT, default 100000, is the number of idle cycles after which a partial block is discarded; 0 disables the timeout.
REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-003 CLK  input  1  sole clock; all state changes on its rising edge.
REQ-004 RST_N  input  1  asynchronous active-low reset.
REQ-005 RX_DATA  input  8  byte from the UART receiver; bit 7 is the first DES bit of the byte.
REQ-006 RX_VALID  input  1  one-cycle strobe; RX_DATA is valid this cycle.
REQ-007 BLK_VALID  output  1  HALF_HI/HALF_LO hold a permuted block.
REQ-008 BLK_READY  input  1  consumer accepts the block when high with BLK_VALID.
REQ-009 HALF_HI  output  32  [32:1]; HALF_HI[j] = IP output bit 32+j.
REQ-010 HALF_LO  output  32  [32:1]; HALF_LO[j] = IP output bit j.
REQ-011 BYTE_CNT  output  3  bytes collected toward the current block (0..7).
REQ-012 OVERRUN  output  1  sticky; a byte was dropped.
REQ-013 CLR_OVR  input  1  synchronous clear of OVERRUN.

Function
REQ-014 The block SHALL assemble 8 RX bytes into PLAIN[64:1]: byte k (k=0..7) fills DES bits 8k+1..8k+8, RX_DATA[7] -> bit 8k+1.
REQ-015 IP output bit i SHALL equal PLAIN[IP(i)], with IP = standard DES initial permutation: 58 50 42 34 26 18 10 2 / 60 52 44 36 28 20 12 4 / 62 54 46 38 30 22 14 6 / 64 56 48 40 32 24 16 8 / 57 49 41 33 25 17 9 1 / 59 51 43 35 27 19 11 3 / 61 53 45 37 29 21 13 5 / 63 55 47 39 31 23 15 7.
REQ-016 The collector FSM SHALL have states COLLECT and FULL; the output stage is a single register guarded by BLK_VALID.
REQ-017 COLLECT: each RX_VALID stores the byte and increments BYTE_CNT; on the 8th byte the permuted block moves to the output register if it is empty or being accepted that cycle, else the FSM enters FULL holding the raw block.
REQ-018 Latency: 8th byte accepted in cycle N -> BLK_VALID high in cycle N+1 (permutation combinational at load).
REQ-019 FULL: when the output register empties (BLK_VALID & BLK_READY), the held block SHALL load the next cycle, BYTE_CNT returns to 0, state returns to COLLECT.
REQ-020 RX_VALID in FULL SHALL drop the byte and set OVERRUN; collected data unchanged.
REQ-021 BLK_VALID SHALL stay high and HALF_HI/HALF_LO stable until accepted; BLK_VALID falls the cycle after acceptance unless a new block loads simultaneously.
REQ-022 In COLLECT with BYTE_CNT>0 and no RX_VALID for IDLE_TIMEOUT consecutive cycles, BYTE_CNT SHALL return to 0 and partial data be discarded; no flag.
REQ-023 CLR_OVR and a simultaneous drop event SHALL leave OVERRUN set (set wins).

Reset
REQ-024 RST_N low SHALL immediately force state COLLECT, BYTE_CNT=0, BLK_VALID=0, HALF_HI=0, HALF_LO=0, OVERRUN=0, idle counter=0, discarding any partial, held or pending block.
REQ-025 Bytes strobed in the first cycle after RST_N deasserts SHALL be accepted normally.

Structure
REQ-026 The IP table, block/half widths and FSM state encoding SHALL live in shared package des_pkg, reused by the other DES blocks.
REQ-027 The permutation SHALL be a separate combinational sub-module des_ip (PLAIN[64:1] in, HALF_HI/HALF_LO out); all sequential logic stays in des_block_loader.

Verification
REQ-028 Bytes 01 23 45 67 89 AB CD EF, BLK_READY=1 -> one BLK_VALID pulse, 1 cycle after 8th byte, {HALF_LO bits 1..32, HALF_HI bits 1..32} = DES IP(0123456789ABCDEF) = CC00CCFF F0AAF0AA.
REQ-029 Round trip: 1000 random blocks -> reference IP^-1 of {HALF_HI,HALF_LO} equals input block each time.
REQ-030 BLK_READY=0, send 16 bytes, then 1 more -> first block held stable, FSM in FULL, 17th byte dropped, OVERRUN=1; raise BLK_READY -> both blocks delivered in order.
REQ-031 IDLE_TIMEOUT=10: send 3 bytes, wait 10 cycles, send 8 bytes -> BYTE_CNT 3 then 0, exactly one block equal to the 8 later bytes.
REQ-032 RST_N pulsed low after 5 bytes and while BLK_VALID=1 -> all outputs 0 immediately; next 8 bytes produce one correct block.
REQ-033 CLR_OVR pulsed in the same cycle as a dropped byte -> OVERRUN remains 1; CLR_OVR alone next cycle -> 0.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES definitions: block/half widths, initial permutation table and
// the block-loader FSM state encoding.
package des_pkg;

   localparam int BLOCK_W         = 64;
   localparam int HALF_W          = 32;
   localparam int BYTE_W          = 8;
   localparam int BYTES_PER_BLOCK = BLOCK_W / BYTE_W;

   // IP_TABLE[i-1] is the PLAIN bit that becomes IP output bit i (DES bit 1 = first bit).
   localparam int unsigned IP_TABLE [BLOCK_W] = '{
      58, 50, 42, 34, 26, 18, 10, 2,
      60, 52, 44, 36, 28, 20, 12, 4,
      62, 54, 46, 38, 30, 22, 14, 6,
      64, 56, 48, 40, 32, 24, 16, 8,
      57, 49, 41, 33, 25, 17,  9, 1,
      59, 51, 43, 35, 27, 19, 11, 3,
      61, 53, 45, 37, 29, 21, 13, 5,
      63, 55, 47, 39, 31, 23, 15, 7
   };

   typedef enum logic {
      ST_COLLECT = 1'b0,
      ST_FULL    = 1'b1
   } loader_state_e;

endpackage

// File: rtl/des_ip.sv
// DES initial permutation: purely combinational bit routing of PLAIN[64:1]
// into the two 32-bit halves.
module des_ip
   import des_pkg::*;
(
   input  logic [BLOCK_W:1] plain,
   output logic [HALF_W:1]  half_hi,
   output logic [HALF_W:1]  half_lo
);

   for (genvar i = 1; i <= HALF_W; i++) begin : g_ip
      assign half_lo[i] = plain[IP_TABLE[i-1]];
      assign half_hi[i] = plain[IP_TABLE[HALF_W+i-1]];
   end

endmodule

// File: rtl/des_block_loader.sv
// Collects UART bytes into 64-bit DES blocks, applies the initial permutation
// and presents the halves through a single valid/ready output register.
module des_block_loader
   import des_pkg::*;
#(
   parameter int IDLE_TIMEOUT = 100000
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [BYTE_W-1:0]   rx_data,
   input  logic                rx_valid,
   output logic                blk_valid,
   input  logic                blk_ready,
   output logic [HALF_W:1]     half_hi,
   output logic [HALF_W:1]     half_lo,
   output logic [2:0]          byte_cnt,
   output logic                overrun,
   input  logic                clr_ovr,
   output loader_state_e       state
);

   localparam int IDLE_W      = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
   localparam int IDLE_LAST_I = (IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0;
   localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_LAST_I[IDLE_W-1:0];

   loader_state_e     state_nxt;
   logic [BYTE_W-1:0] bytes_q   [BYTES_PER_BLOCK];
   logic [BYTE_W-1:0] blk_bytes [BYTES_PER_BLOCK];
   logic [BLOCK_W:1]  plain;
   logic [HALF_W:1]   ip_hi;
   logic [HALF_W:1]   ip_lo;
   logic [IDLE_W-1:0] idle_cnt;
   logic              out_free;
   logic              last_byte;
   logic              idle_fire;
   logic              take_byte;
   logic              drop_byte;
   logic              load_out;
   logic              clr_cnt;

   // In COLLECT the incoming byte is merged in so the 8th byte can load the
   // output register in the same cycle it arrives.
   always_comb begin
      blk_bytes = bytes_q;
      if (state == ST_COLLECT) blk_bytes[byte_cnt] = rx_data;
   end

   for (genvar k = 0; k < BYTES_PER_BLOCK; k++) begin : g_byte
      for (genvar m = 0; m < BYTE_W; m++) begin : g_bit
         assign plain[BYTE_W*k+1+m] = blk_bytes[k][BYTE_W-1-m];
      end
   end

   des_ip u_ip (
      .plain   (plain),
      .half_hi (ip_hi),
      .half_lo (ip_lo)
   );

   // Output handshake: a block transfers on every rising edge where blk_valid
   // and blk_ready are both high; while blk_valid is high without blk_ready the
   // halves are held unchanged.
   assign out_free  = !blk_valid || blk_ready;
   assign last_byte = (byte_cnt == 3'(BYTES_PER_BLOCK - 1));
   assign idle_fire = (IDLE_TIMEOUT != 0) && (state == ST_COLLECT) && !rx_valid &&
                      (byte_cnt != 3'd0) && (idle_cnt == IDLE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_COLLECT;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      take_byte = 1'b0;
      drop_byte = 1'b0;
      load_out  = 1'b0;
      clr_cnt   = 1'b0;
      case (state)
         ST_COLLECT: begin
            if (rx_valid) begin
               take_byte = 1'b1;
               if (last_byte) begin
                  if (out_free) begin
                     load_out = 1'b1;
                     clr_cnt  = 1'b1;
                  end else begin
                     state_nxt = ST_FULL;
                  end
               end
            end else if (idle_fire) begin
               clr_cnt = 1'b1;
            end
         end
         ST_FULL: begin
            drop_byte = rx_valid;
            if (blk_valid && blk_ready) begin
               load_out  = 1'b1;
               clr_cnt   = 1'b1;
               state_nxt = ST_COLLECT;
            end
         end
         default: state_nxt = ST_COLLECT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < BYTES_PER_BLOCK; k++) bytes_q[k] <= '0;
         byte_cnt  <= '0;
         idle_cnt  <= '0;
         blk_valid <= 1'b0;
         half_hi   <= '0;
         half_lo   <= '0;
         overrun   <= 1'b0;
      end else begin
         if (take_byte) bytes_q[byte_cnt] <= rx_data;

         // A full block parked in FULL keeps byte_cnt at 7 until it loads.
         if (clr_cnt)                      byte_cnt <= '0;
         else if (take_byte && !last_byte) byte_cnt <= byte_cnt + 3'd1;

         if (state == ST_COLLECT && !rx_valid && byte_cnt != 3'd0 && !idle_fire)
            idle_cnt <= idle_cnt + 1'b1;
         else
            idle_cnt <= '0;

         if (load_out) begin
            blk_valid <= 1'b1;
            half_hi   <= ip_hi;
            half_lo   <= ip_lo;
         end else if (blk_ready) begin
            blk_valid <= 1'b0;
         end

         if (drop_byte)    overrun <= 1'b1;
         else if (clr_ovr) overrun <= 1'b0;
      end
   end

endmodule

// File: tb/tb_des_block_loader.sv
// Self-checking bench for des_block_loader: directed vectors, a round-trip
// scoreboard using the inverse permutation, back-pressure, timeout and reset.
module tb_des_block_loader;
   import des_pkg::*;

   localparam int IDLE = 10;

   logic          clk;
   logic          rst_n;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          blk_valid;
   logic          blk_ready;
   logic [32:1]   half_hi;
   logic [32:1]   half_lo;
   logic [2:0]    byte_cnt;
   logic          overrun;
   logic          clr_ovr;
   loader_state_e state;

   des_block_loader #(.IDLE_TIMEOUT(IDLE)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .half_hi   (half_hi),
      .half_lo   (half_lo),
      .byte_cnt  (byte_cnt),
      .overrun   (overrun),
      .clr_ovr   (clr_ovr),
      .state     (state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int tests = 0;
   int fails = 0;
   logic [63:0] exp_q[$];

   // Inverse initial permutation (DES final permutation).
   localparam int FP_TABLE [64] = '{
      40, 8, 48, 16, 56, 24, 64, 32,
      39, 7, 47, 15, 55, 23, 63, 31,
      38, 6, 46, 14, 54, 22, 62, 30,
      37, 5, 45, 13, 53, 21, 61, 29,
      36, 4, 44, 12, 52, 20, 60, 28,
      35, 3, 43, 11, 51, 19, 59, 27,
      34, 2, 42, 10, 50, 18, 58, 26,
      33, 1, 41,  9, 49, 17, 57, 25
   };

   // IP output bits 1..64 packed MSB-first: {half_lo bits 1..32, half_hi bits 1..32}.
   function automatic logic [63:0] ip_hex(input logic [32:1] hi, input logic [32:1] lo);
      logic [63:0] r;
      r = '0;
      for (int j = 1; j <= 32; j++) begin
         r[64-j] = lo[j];
         r[32-j] = hi[j];
      end
      return r;
   endfunction

   function automatic logic [63:0] inv_ip(input logic [63:0] ipv);
      logic [63:0] p;
      p = '0;
      for (int i = 1; i <= 64; i++) p[64-i] = ipv[64-FP_TABLE[i-1]];
      return p;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (rst_n && blk_valid && blk_ready) begin
         if (exp_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL unexpected_block: got %h expected none",
                     inv_ip(ip_hex(half_hi, half_lo)));
         end else begin
            check("roundtrip", inv_ip(ip_hex(half_hi, half_lo)), exp_q.pop_front());
         end
      end
   end

   // driver tasks (called in the posedge+1 phase)
   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(posedge clk);
      #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_block(input logic [63:0] blk, input bit expect_out, input int max_gap);
      if (expect_out) exp_q.push_back(blk);
      for (int k = 0; k < 8; k++) begin
         send_byte(blk[63-8*k -: 8]);
         if (max_gap > 0 && k < 7) tick($urandom_range(0, max_gap));
      end
   endtask

   task automatic run_directed(input string name, input logic [63:0] plain, input logic [63:0] exp_ip);
      send_block(plain, 1'b1, 0);
      check({name, "_latency"}, 64'(blk_valid), 64'd1);
      check({name, "_ip"}, ip_hex(half_hi, half_lo), exp_ip);
      check({name, "_cnt"}, 64'(byte_cnt), 64'd0);
      tick(1);
      check({name, "_pulse"}, 64'(blk_valid), 64'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      rx_data   = '0;
      rx_valid  = 1'b0;
      blk_ready = 1'b0;
      clr_ovr   = 1'b0;
      tick(3);
      check("rst_valid", 64'(blk_valid), 64'd0);
      check("rst_cnt", 64'(byte_cnt), 64'd0);
      check("rst_ovr", 64'(overrun), 64'd0);
      check("rst_halves", ip_hex(half_hi, half_lo), 64'd0);
      check("rst_state", 64'(state), 64'(ST_COLLECT));

      // first byte strobed in the very first cycle out of reset
      rst_n     = 1'b1;
      blk_ready = 1'b1;
      run_directed("std", 64'h0123456789ABCDEF, 64'hCC00CCFFF0AAF0AA);
      run_directed("lsb", 64'h0000000000000001, 64'h0000008000000000);
      run_directed("msb", 64'h8000000000000000, 64'h0000000001000000);

      for (int n = 0; n < 1000; n++) send_block({$urandom, $urandom}, 1'b1, 2);
      tick(3);

      // back-pressure, FULL, dropped bytes and overrun clear
      blk_ready = 1'b0;
      send_block(64'h0123456789ABCDEF, 1'b1, 0);
      send_block(64'hFEDCBA9876543210, 1'b1, 0);
      check("full_state", 64'(state), 64'(ST_FULL));
      check("full_valid", 64'(blk_valid), 64'd1);
      check("full_hold", ip_hex(half_hi, half_lo), 64'hCC00CCFFF0AAF0AA);
      check("full_ovr0", 64'(overrun), 64'd0);
      send_byte(8'h5A);
      check("drop_ovr", 64'(overrun), 64'd1);
      check("drop_hold", ip_hex(half_hi, half_lo), 64'hCC00CCFFF0AAF0AA);
      clr_ovr = 1'b1;
      send_byte(8'hA5);
      clr_ovr = 1'b0;
      check("ovr_set_wins", 64'(overrun), 64'd1);
      clr_ovr = 1'b1;
      tick(1);
      clr_ovr = 1'b0;
      check("ovr_clear", 64'(overrun), 64'd0);
      check("still_full", 64'(state), 64'(ST_FULL));
      blk_ready = 1'b1;
      tick(1);
      check("full_exit_state", 64'(state), 64'(ST_COLLECT));
      check("full_exit_cnt", 64'(byte_cnt), 64'd0);
      check("full_exit_valid", 64'(blk_valid), 64'd1);
      tick(1);
      check("full_drained", 64'(blk_valid), 64'd0);

      // idle timeout discards a partial block
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      check("to_cnt3", 64'(byte_cnt), 64'd3);
      tick(IDLE - 1);
      check("to_before", 64'(byte_cnt), 64'd3);
      tick(1);
      check("to_after", 64'(byte_cnt), 64'd0);
      send_block(64'h1122334455667788, 1'b1, 0);
      tick(2);
      check("to_one_block", 64'(exp_q.size()), 64'd0);
      check("to_idle_valid", 64'(blk_valid), 64'd0);

      // asynchronous reset with a pending block and a partial
      blk_ready = 1'b0;
      send_block(64'h0F1E2D3C4B5A6978, 1'b0, 0);
      for (int k = 0; k < 5; k++) send_byte(8'(k + 1));
      check("pre_rst_valid", 64'(blk_valid), 64'd1);
      check("pre_rst_cnt", 64'(byte_cnt), 64'd5);
      rst_n = 1'b0;
      #1;
      check("arst_valid", 64'(blk_valid), 64'd0);
      check("arst_cnt", 64'(byte_cnt), 64'd0);
      check("arst_halves", ip_hex(half_hi, half_lo), 64'd0);
      check("arst_ovr", 64'(overrun), 64'd0);
      check("arst_state", 64'(state), 64'(ST_COLLECT));
      tick(1);
      rst_n     = 1'b1;
      blk_ready = 1'b1;
      send_block(64'hDEADBEEFCAFEF00D, 1'b1, 0);
      check("post_rst_valid", 64'(blk_valid), 64'd1);

      for (int w = 0; w < 20 && exp_q.size() != 0; w++) tick(1);
      check("queue_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
